// File: rtl/binary_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter: one input bit per clock, start/busy/done
// handshake, result held in a register so downstream segment encoders never see partial values.
module binary_to_bcd_seq #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      bin_in_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [5*DIGITS-1:0]   digits_out_o
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic bit range_ok();
        longint unsigned p;
        p = 1;
        for (int i = 0; i < DIGITS; i++) p = p * 10;
        return p > ((64'd1 << WIDTH) - 1);
    endfunction

    if (!range_ok()) begin : g_range_chk
        $error("binary_to_bcd_seq: 10**DIGITS must exceed 2**WIDTH-1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [WIDTH-1:0]    sh_q, sh_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [5*DIGITS-1:0] dig_q, dig_d;
    logic                busy_q, done_q;

    logic [BW-1:0]       bcd_adj;
    logic [BW-1:0]       bcd_shift;
    logic [WIDTH-1:0]    sh_shift;
    logic [5*DIGITS-1:0] bcd_padded;

    // Per-nibble add-3 correction; nibbles are independent, no carry between them.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [3:0] nib;
        assign nib                 = bcd_q[4*g +: 4];
        assign bcd_adj[4*g +: 4]   = (nib >= 4'd5) ? nib + 4'd3 : nib;
        assign bcd_padded[5*g +: 5] = {1'b0, bcd_shift[4*g +: 4]};
    end

    assign {bcd_shift, sh_shift} = {bcd_adj, sh_q} << 1;

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    sh_d    = bin_in_i;
                    bcd_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                bcd_d = bcd_shift;
                sh_d  = sh_shift;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    dig_d   = bcd_padded;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            busy_q  <= (state_d == SHIFT);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign digits_out_o = dig_q;

endmodule
